// File: rtl/instrumented_adder_pkg.sv
// rtl/instrumented_adder_pkg.sv - shared state type and default widths for the adder measurement sequencer
package instrumented_adder_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_SETTLE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_CAPTURE,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with synchronous active-high reset
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two back-to-back flops give an asynchronous input a cycle to resolve metastability
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instrumented_adder_seq.sv
// rtl/instrumented_adder_seq.sv - load/settle/launch/time sequencer around the instrumented adder
module instrumented_adder_seq
  import instrumented_adder_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SETTLE_W = DEF_SETTLE_W
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic [WIDTH-1:0]    cfg_a,
  input  logic [WIDTH-1:0]    cfg_b,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic [CNT_W-1:0]    cfg_timeout,
  output logic [WIDTH-1:0]    add_a,
  output logic [WIDTH-1:0]    add_b,
  output logic                add_run,
  input  logic                add_chain_out,
  input  logic [WIDTH-1:0]    add_sum,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic                stale,
  output logic                aborted,
  output logic [WIDTH-1:0]    result_sum,
  output logic [CNT_W-1:0]    result_cycles,
  output logic [CNT_W-1:0]    run_count
);

  seq_state_t          r_state;
  logic                r_start_q;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_add_a;
  logic [WIDTH-1:0]    r_add_b;
  logic [WIDTH-1:0]    r_result_sum;
  logic [CNT_W-1:0]    r_result_cycles;
  logic [CNT_W-1:0]    r_run_count;
  logic                r_timeout;
  logic                r_stale;
  logic                r_aborted;

  logic                w_chain_s;
  logic                w_start_edge;
  logic [CNT_W-1:0]    w_eff_timeout;

  sync2 u_chain_sync (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_d   (add_chain_out),
    .o_q   (w_chain_s)
  );

  assign w_start_edge  = start & ~r_start_q;
  // A zero timeout selects the longest measurable run rather than an instant expiry
  assign w_eff_timeout = (cfg_timeout == '0) ? '1 : cfg_timeout;

  // Sequencer: start-edge detect, run FSM, settle/run counters, sticky flags and result capture
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state         <= ST_IDLE;
      r_start_q       <= 1'b0;
      r_settle_cnt    <= '0;
      r_cnt           <= '0;
      r_add_a         <= '0;
      r_add_b         <= '0;
      r_result_sum    <= '0;
      r_result_cycles <= '0;
      r_run_count     <= '0;
      r_timeout       <= 1'b0;
      r_stale         <= 1'b0;
      r_aborted       <= 1'b0;
    end else begin
      r_start_q <= start;
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Flags describe the new run even if it is abandoned before operands load
          r_timeout <= 1'b0;
          r_stale   <= 1'b0;
          if (!start) begin
            r_aborted <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_aborted    <= 1'b0;
            r_add_a      <= cfg_a;
            r_add_b      <= cfg_b;
            r_settle_cnt <= (cfg_settle == '0) ? SETTLE_W'(1) : cfg_settle;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!start) begin
            r_aborted <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (r_settle_cnt == SETTLE_W'(1)) begin
            // A chain still reporting completion before launch cannot be timed
            if (w_chain_s) begin
              r_stale <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= ST_RUN;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
          end
        end
        ST_RUN: begin
          if (!start) begin
            r_aborted <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (w_chain_s) begin
            r_state <= ST_CAPTURE;
          end else if (r_cnt == w_eff_timeout) begin
            r_timeout <= 1'b1;
            r_state   <= ST_CAPTURE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          r_result_sum    <= add_sum;
          r_result_cycles <= r_cnt;
          r_run_count     <= r_run_count + CNT_W'(1);
          r_state         <= ST_DONE;
        end
        ST_DONE: begin
          if (!start) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign add_a         = r_add_a;
  assign add_b         = r_add_b;
  assign add_run       = (r_state == ST_RUN);
  assign busy          = (r_state == ST_LOAD) || (r_state == ST_SETTLE) ||
                         (r_state == ST_RUN)  || (r_state == ST_CAPTURE);
  assign done          = (r_state == ST_DONE);
  assign timeout       = r_timeout;
  assign stale         = r_stale;
  assign aborted       = r_aborted;
  assign result_sum    = r_result_sum;
  assign result_cycles = r_result_cycles;
  assign run_count     = r_run_count;

endmodule

// File: tb/tb_instrumented_adder_seq.sv
// tb/tb_instrumented_adder_seq.sv - randomized and directed self-checking bench for instrumented_adder_seq
module tb_instrumented_adder_seq;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_a = '0;
  logic [31:0] cfg_b = '0;
  logic [7:0]  cfg_settle = '0;
  logic [15:0] cfg_timeout = '0;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_run;
  logic        add_chain_out = 1'b0;
  logic [31:0] add_sum;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        stale;
  logic        aborted;
  logic [31:0] result_sum;
  logic [15:0] result_cycles;
  logic [15:0] run_count;

  int n_tests = 0;
  int n_fail = 0;
  int n_prints = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  // The bench plays the adder: its sum is simply the configured operands added
  assign add_sum = cfg_a + cfg_b;

  instrumented_adder_seq dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .start         (start),
    .cfg_a         (cfg_a),
    .cfg_b         (cfg_b),
    .cfg_settle    (cfg_settle),
    .cfg_timeout   (cfg_timeout),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_run       (add_run),
    .add_chain_out (add_chain_out),
    .add_sum       (add_sum),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .stale         (stale),
    .aborted       (aborted),
    .result_sum    (result_sum),
    .result_cycles (result_cycles),
    .run_count     (run_count)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_prints < 40) begin
        n_prints++;
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
    end
  endfunction

  // Reference model: a run is tracked by its position p counted in cycles since the start edge
  // (p=0 load, 1..S settle, S+1.. run with run index p-S); chain_s is the raw chain two edges ago.
  logic        m_valid = 1'b0;
  logic        m_busy, m_done, m_run, m_capture, m_start_q;
  logic        m_to, m_st, m_ab;
  logic [31:0] m_a, m_b, m_rs;
  logic [15:0] m_rc, m_cnt;
  int          m_p, m_s, m_cyc;
  logic        h1, h2;

  always @(negedge wb_clk_i) begin
    logic chs;
    logic sedge;
    int   n;
    int   eff;
    if (m_valid) begin
      chk("add_a", add_a, m_a);
      chk("add_b", add_b, m_b);
      chk("add_run", add_run, m_run);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("timeout", timeout, m_to);
      chk("stale", stale, m_st);
      chk("aborted", aborted, m_ab);
      chk("result_sum", result_sum, m_rs);
      chk("result_cycles", result_cycles, m_rc);
      chk("run_count", run_count, m_cnt);
    end
    // Inputs seen now are exactly those the next rising edge samples
    chs = h2;
    eff = (cfg_timeout == 16'd0) ? 65535 : int'(cfg_timeout);
    if (wb_rst_i) begin
      m_valid = 1'b1;
      m_busy = 0; m_done = 0; m_run = 0; m_capture = 0; m_start_q = 0;
      m_to = 0; m_st = 0; m_ab = 0;
      m_a = 0; m_b = 0; m_rs = 0; m_rc = 0; m_cnt = 0;
      m_p = 0; m_s = 0; m_cyc = 0;
      h1 = 0; h2 = 0;
    end else begin
      sedge = start && !m_start_q;
      if (m_done) begin
        if (!start) m_done = 0;
      end else if (!m_busy) begin
        if (sedge) begin
          m_busy = 1;
          m_p = 0;
        end
      end else if (m_capture) begin
        m_rs = add_sum;
        m_rc = 16'(m_cyc);
        m_cnt = m_cnt + 16'd1;
        m_capture = 0;
        m_busy = 0;
        m_done = 1;
      end else if (!start) begin
        m_busy = 0;
        m_run = 0;
        m_ab = 1;
        if (m_p == 0) begin
          m_to = 0;
          m_st = 0;
        end
      end else if (m_p == 0) begin
        m_a = cfg_a;
        m_b = cfg_b;
        m_to = 0; m_st = 0; m_ab = 0;
        m_s = (cfg_settle == 8'd0) ? 1 : int'(cfg_settle);
        m_p = 1;
      end else if (m_p <= m_s) begin
        if (m_p == m_s) begin
          if (chs) begin
            m_st = 1;
            m_busy = 0;
            m_done = 1;
          end else begin
            m_run = 1;
          end
        end
        m_p++;
      end else begin
        n = m_p - m_s;
        if (chs) begin
          m_cyc = n;
          m_capture = 1;
          m_run = 0;
        end else if (n == eff) begin
          m_cyc = n;
          m_to = 1;
          m_capture = 1;
          m_run = 0;
        end
        m_p++;
      end
      m_start_q = start;
      h2 = h1;
      h1 = add_chain_out;
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // One run: chain rises during run cycle chain_c (0 = never), optional stale chain,
  // abort during run cycle abort_rc, or a reset pulse during run cycle rst_rc.
  task automatic do_run(input logic [31:0] a, input logic [31:0] b, input logic [7:0] s,
                        input logic [15:0] to, input int chain_c, input bit stale_mode,
                        input int abort_rc, input int rst_rc,
                        output int run_cycles, output int lat);
    int cyc;
    int b_at;
    int r_at;
    int rcyc;
    bit stop;
    cfg_a = a;
    cfg_b = b;
    cfg_settle = s;
    cfg_timeout = to;
    add_chain_out = stale_mode;
    if (stale_mode) repeat (3) tick();
    start = 1'b1;
    cyc = 0; b_at = -1; r_at = -1; rcyc = 0; stop = 0;
    while (!stop && cyc < 400) begin
      tick();
      cyc++;
      if (busy && b_at < 0) b_at = cyc;
      if (done) begin
        stop = 1;
      end else if (add_run) begin
        if (r_at < 0) r_at = cyc;
        rcyc++;
        if (chain_c > 0 && rcyc >= chain_c) add_chain_out = 1'b1;
        if (abort_rc > 0 && rcyc == abort_rc) begin
          start = 1'b0;
          tick();
          stop = 1;
        end else if (rst_rc > 0 && rcyc == rst_rc) begin
          wb_rst_i = 1'b1;
          tick();
          wb_rst_i = 1'b0;
          stop = 1;
        end
      end
    end
    chk("run_bound", stop, 1'b1);
    run_cycles = rcyc;
    lat = (r_at < 0 || b_at < 0) ? -1 : (r_at - b_at);
  endtask

  task automatic finish_run(input int hold);
    repeat (hold) tick();
    start = 1'b0;
    add_chain_out = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rc;
    int lat;
    int c;
    bit st;
    int ab;
    logic [15:0] to;
    logic [15:0] rc_before;

    repeat (3) tick();
    wb_rst_i = 1'b0;
    tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_run_count", run_count, 16'd0);
    chk("reset_add_a", add_a, 32'd0);

    // Normal run: 5+7, settle 3, chain rises in the 4th run cycle
    do_run(32'd5, 32'd7, 8'd3, 16'd0, 4, 0, 0, 0, rc, lat);
    chk("normal_settle_cycles", lat - 1, 3);
    chk("normal_result_sum", result_sum, 32'd12);
    chk("normal_result_cycles", result_cycles, 16'd6);
    chk("normal_run_count", run_count, 16'd1);
    chk("normal_done", done, 1'b1);
    repeat (5) tick();
    chk("held_start_done", done, 1'b1);
    chk("held_start_no_rerun", busy, 1'b0);
    chk("held_start_run_count", run_count, 16'd1);
    start = 1'b0;
    tick();
    chk("done_drops", done, 1'b0);
    finish_run(0);

    // Timeout after exactly 10 run cycles
    do_run(32'd100, 32'd23, 8'd2, 16'd10, 0, 0, 0, 0, rc, lat);
    chk("timeout_run_cycles", rc, 10);
    chk("timeout_flag", timeout, 1'b1);
    chk("timeout_result_cycles", result_cycles, 16'd10);
    chk("timeout_done", done, 1'b1);
    chk("timeout_run_count", run_count, 16'd2);
    finish_run(1);

    // Stale chain held high through settle
    do_run(32'd1, 32'd1, 8'd3, 16'd0, 0, 1, 0, 0, rc, lat);
    chk("stale_no_run", rc, 0);
    chk("stale_flag", stale, 1'b1);
    chk("stale_done", done, 1'b1);
    chk("stale_run_count", run_count, 16'd2);
    finish_run(1);

    // Abort on the 3rd run cycle
    do_run(32'd9, 32'd9, 8'd2, 16'd0, 0, 0, 3, 0, rc, lat);
    chk("abort_idle", busy, 1'b0);
    chk("abort_flag", aborted, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_run_count", run_count, 16'd2);
    chk("abort_result_sum", result_sum, 32'd123);
    chk("abort_result_cycles", result_cycles, 16'd10);
    finish_run(0);

    // Reset pulse in the 2nd run cycle
    do_run(32'd44, 32'd55, 8'd1, 16'd0, 0, 0, 0, 2, rc, lat);
    chk("rst_busy", busy, 1'b0);
    chk("rst_add_run", add_run, 1'b0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_run_count", run_count, 16'd0);
    chk("rst_result_sum", result_sum, 32'd0);
    chk("rst_aborted", aborted, 1'b0);
    finish_run(0);

    do_run(32'd5, 32'd7, 8'd3, 16'd0, 4, 0, 0, 0, rc, lat);
    chk("post_rst_result_cycles", result_cycles, 16'd6);
    chk("post_rst_run_count", run_count, 16'd1);
    finish_run(2);

    // Settle 0 behaves as one settle cycle
    do_run(32'd3, 32'd4, 8'd0, 16'd0, 2, 0, 0, 0, rc, lat);
    chk("settle0_cycles", lat - 1, 1);
    chk("b2b_run_count", run_count, 16'd2);
    chk("settle0_result_sum", result_sum, 32'd7);
    finish_run(1);

    // Randomized runs, checked cycle by cycle by the model
    for (int i = 0; i < 40; i++) begin
      c  = $urandom_range(0, 15);
      st = ($urandom_range(0, 9) == 0);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      to = (c > 0 && $urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      rc_before = run_count;
      do_run($urandom, $urandom, 8'($urandom_range(0, 6)), to, c, st, ab, 0, rc, lat);
      if (done && !stale) chk("rand_run_count_step", run_count, rc_before + 16'd1);
      finish_run($urandom_range(0, 3));
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
